// File: rtl/eh2_lsu_busclk_ctl.sv
// LSU bus clock-enable generator with a programmable core-to-bus ratio.
// Ratio code r produces one bus-cycle enable pulse every r+1 core cycles.
// Ratio changes only take effect on a bus-cycle boundary, so the enable
// never produces a short or merged pulse. Also aligns each thread's
// force-halt request to bus-cycle boundaries and reports when the bus side
// has quiesced for that thread.
module eh2_lsu_busclk_ctl #(
    parameter int unsigned             NUM_THREADS = 1,
    parameter int unsigned             RATIO_W     = 3,
    parameter logic [RATIO_W-1:0]      RST_RATIO   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RATIO_W-1:0]         bus_ratio,
    input  logic                       ratio_update,
    input  logic [NUM_THREADS-1:0]     dec_tlu_force_halt,
    input  logic [NUM_THREADS-1:0]     lsu_bus_buffer_empty_any,
    output logic                       lsu_bus_clk_en,
    output logic                       lsu_bus_clk_en_q,
    output logic [NUM_THREADS-1:0]     dec_tlu_force_halt_bus,
    output logic [NUM_THREADS-1:0]     force_halt_done,
    output logic [RATIO_W-1:0]         ratio_q,
    output logic                       ratio_pend
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HALT  = 2'd2,
        ST_DONE  = 2'd3
    } halt_state_e;

    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] ratio_cur_q, ratio_cur_d;
    logic [RATIO_W-1:0] pend_ratio_q, pend_ratio_d;
    logic               pend_q, pend_d;
    logic               clk_en_q;
    logic               clk_en_dly_q;
    logic               boundary;

    // Divider and ratio-update next state; a boundary always restarts the count
    always_comb begin
        boundary     = (cnt_q == ratio_cur_q);
        cnt_d        = boundary ? '0 : cnt_q + RATIO_W'(1);
        ratio_cur_d  = ratio_cur_q;
        pend_ratio_d = pend_ratio_q;
        pend_d       = pend_q;
        if (boundary) begin
            // A request landing on the boundary itself bypasses any older pending code
            pend_d = 1'b0;
            if (ratio_update) begin
                ratio_cur_d = bus_ratio;
            end else if (pend_q) begin
                ratio_cur_d = pend_ratio_q;
            end
        end else if (ratio_update) begin
            // Last request before the boundary wins
            pend_d       = 1'b1;
            pend_ratio_d = bus_ratio;
        end
    end

    // Divider, ratio and enable registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            ratio_cur_q  <= RST_RATIO;
            pend_ratio_q <= '0;
            pend_q       <= 1'b0;
            clk_en_q     <= 1'b0;
            clk_en_dly_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ratio_cur_q  <= ratio_cur_d;
            pend_ratio_q <= pend_ratio_d;
            pend_q       <= pend_d;
            clk_en_q     <= boundary;
            clk_en_dly_q <= clk_en_q;
        end
    end

    assign lsu_bus_clk_en   = clk_en_q;
    assign lsu_bus_clk_en_q = clk_en_dly_q;
    assign ratio_q          = ratio_cur_q;
    assign ratio_pend       = pend_q;

    // One independent force-halt sequencer per thread; "bus edge" means an
    // edge on which the registered bus clock enable is high.
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thr
        halt_state_e st_q, st_d;

        // Per-thread halt state register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q <= ST_IDLE;
            end else begin
                st_q <= st_d;
            end
        end

        // Per-thread halt next-state; HALT cannot be aborted by dropping the request
        always_comb begin
            st_d = st_q;
            case (st_q)
                ST_IDLE: begin
                    if (dec_tlu_force_halt[gi]) st_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!dec_tlu_force_halt[gi]) st_d = ST_IDLE;
                    else if (clk_en_q)           st_d = ST_HALT;
                end
                ST_HALT: begin
                    if (clk_en_q && lsu_bus_buffer_empty_any[gi]) st_d = ST_DONE;
                end
                ST_DONE: begin
                    if (!dec_tlu_force_halt[gi]) st_d = ST_IDLE;
                end
                default: st_d = ST_IDLE;
            endcase
        end

        assign dec_tlu_force_halt_bus[gi] = (st_q == ST_HALT) || (st_q == ST_DONE);
        assign force_halt_done[gi]        = (st_q == ST_DONE);
    end

endmodule

// File: tb/tb_eh2_lsu_busclk_ctl.sv
// Self-checking bench for eh2_lsu_busclk_ctl: a behavioural model predicts
// every output per clock edge through a scoreboard queue, and directed checks
// against fixed values cover the specific timing scenarios.
module tb_eh2_lsu_busclk_ctl;

    localparam int unsigned NT = 2;
    localparam int unsigned RW = 3;
    localparam logic [RW-1:0] RR = 3'd3;

    logic          clk;
    logic          rst;
    logic [RW-1:0] bus_ratio;
    logic          ratio_update;
    logic [NT-1:0] dec_tlu_force_halt;
    logic [NT-1:0] lsu_bus_buffer_empty_any;
    logic          lsu_bus_clk_en;
    logic          lsu_bus_clk_en_q;
    logic [NT-1:0] dec_tlu_force_halt_bus;
    logic [NT-1:0] force_halt_done;
    logic [RW-1:0] ratio_q;
    logic          ratio_pend;

    eh2_lsu_busclk_ctl #(
        .NUM_THREADS (NT),
        .RATIO_W     (RW),
        .RST_RATIO   (RR)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .bus_ratio                (bus_ratio),
        .ratio_update             (ratio_update),
        .dec_tlu_force_halt       (dec_tlu_force_halt),
        .lsu_bus_buffer_empty_any (lsu_bus_buffer_empty_any),
        .lsu_bus_clk_en           (lsu_bus_clk_en),
        .lsu_bus_clk_en_q         (lsu_bus_clk_en_q),
        .dec_tlu_force_halt_bus   (dec_tlu_force_halt_bus),
        .force_halt_done          (force_halt_done),
        .ratio_q                  (ratio_q),
        .ratio_pend               (ratio_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic          en_q;
        logic [NT-1:0] hb;
        logic [NT-1:0] dn;
        logic [RW-1:0] ratio;
        logic          pend;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model state
    logic [RW-1:0] m_cnt, m_ratio, m_pend_ratio;
    logic          m_pend, m_en, m_en_q;
    int            m_st[NT];   // 0 idle, 1 armed, 2 halt, 3 done

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cnt = '0; m_ratio = RR; m_pend_ratio = '0;
        m_pend = 1'b0; m_en = 1'b0; m_en_q = 1'b0;
        for (int t = 0; t < NT; t++) m_st[t] = 0;
    endtask

    // Advance the model by one edge using the inputs currently applied
    task automatic model_step();
        logic bnd;
        bnd = (m_cnt == m_ratio);
        for (int t = 0; t < NT; t++) begin
            case (m_st[t])
                0: if (dec_tlu_force_halt[t]) m_st[t] = 1;
                1: if (!dec_tlu_force_halt[t]) m_st[t] = 0;
                   else if (m_en) m_st[t] = 2;
                2: if (m_en && lsu_bus_buffer_empty_any[t]) m_st[t] = 3;
                default: if (!dec_tlu_force_halt[t]) m_st[t] = 0;
            endcase
        end
        m_en_q = m_en;
        m_en   = bnd;
        if (bnd) begin
            m_cnt = '0;
            if (ratio_update) m_ratio = bus_ratio;
            else if (m_pend)  m_ratio = m_pend_ratio;
            m_pend = 1'b0;
        end else begin
            m_cnt = m_cnt + 3'd1;
            if (ratio_update) begin
                m_pend       = 1'b1;
                m_pend_ratio = bus_ratio;
            end
        end
    endtask

    // One clock transaction: predict, push, clock, pop, compare
    task automatic tick();
        exp_t e;
        model_step();
        e.en = m_en; e.en_q = m_en_q; e.ratio = m_ratio; e.pend = m_pend;
        for (int t = 0; t < NT; t++) begin
            e.hb[t] = (m_st[t] >= 2);
            e.dn[t] = (m_st[t] == 3);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        $display("cyc %0d en=%0b enq=%0b hb=%b dn=%b ratio=%0d pend=%0b",
                 cyc, lsu_bus_clk_en, lsu_bus_clk_en_q, dec_tlu_force_halt_bus,
                 force_halt_done, ratio_q, ratio_pend);
        chk("sb_en",    lsu_bus_clk_en,         e.en);
        chk("sb_en_q",  lsu_bus_clk_en_q,       e.en_q);
        chk("sb_hb",    dec_tlu_force_halt_bus, e.hb);
        chk("sb_done",  force_halt_done,        e.dn);
        chk("sb_ratio", ratio_q,                e.ratio);
        chk("sb_pend",  ratio_pend,             e.pend);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_en"},    lsu_bus_clk_en,         0);
        chk({tag, "_en_q"},  lsu_bus_clk_en_q,       0);
        chk({tag, "_hb"},    dec_tlu_force_halt_bus, 0);
        chk({tag, "_done"},  force_halt_done,        0);
        chk({tag, "_ratio"}, ratio_q,                RR);
        chk({tag, "_pend"},  ratio_pend,             0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit found;

        rst = 1'b1;
        bus_ratio = '0;
        ratio_update = 1'b0;
        dec_tlu_force_halt = '0;
        lsu_bus_buffer_empty_any = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst0");
        rst = 1'b0;

        // 1: pulses after edges 4, 8, 12 and delayed copy one edge later
        for (int e = 1; e <= 13; e++) begin
            tick();
            chk("t1_en",   lsu_bus_clk_en,   (e % 4 == 0));
            chk("t1_en_q", lsu_bus_clk_en_q, (e > 1) && ((e - 1) % 4 == 0));
        end

        // 2: update to ratio 1 at cnt=1 of a ratio-3 period
        for (int i = 0; i < 8 && m_cnt != 1; i++) tick();
        bus_ratio = 3'd1; ratio_update = 1'b1;
        tick();
        ratio_update = 1'b0;
        chk("t2_pend_a", ratio_pend, 1);
        tick();
        chk("t2_pend_b", ratio_pend, 1);
        chk("t2_nopulse", lsu_bus_clk_en, 0);
        tick();
        chk("t2_pend_clr", ratio_pend, 0);
        chk("t2_pulse", lsu_bus_clk_en, 1);
        chk("t2_ratio", ratio_q, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_div2", lsu_bus_clk_en, (k % 2 == 1));
        end

        // 3: pending 5, then bypass update to 0 on the boundary edge
        for (int i = 0; i < 8 && m_cnt != 0; i++) tick();
        bus_ratio = 3'd5; ratio_update = 1'b1;
        tick();
        chk("t3_pend5", ratio_pend, 1);
        chk("t3_ratio_hold", ratio_q, 1);
        bus_ratio = 3'd0;
        tick();
        ratio_update = 1'b0;
        chk("t3_ratio0", ratio_q, 0);
        chk("t3_pend0", ratio_pend, 0);
        chk("t3_pulse", lsu_bus_clk_en, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_every", lsu_bus_clk_en, 1);
        end

        // 4: ratio 2, force-halt on both threads; thread 0 bus buffer busy
        bus_ratio = 3'd2; ratio_update = 1'b1;
        tick();
        ratio_update = 1'b0;
        chk("t4_ratio2", ratio_q, 2);
        dec_tlu_force_halt = 2'b11;
        lsu_bus_buffer_empty_any = 2'b10;
        tick();
        chk("t4_armed_nohalt", dec_tlu_force_halt_bus, 0);
        lat = 0; found = 0;
        for (int i = 1; i <= 6 && !found; i++) begin
            tick();
            if (dec_tlu_force_halt_bus[0]) begin found = 1; lat = i; end
        end
        chk("t4_halt_seen", found, 1);
        chk("t4_halt_lat", lat, 3);
        chk("t4_both_halt", dec_tlu_force_halt_bus, 2'b11);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t4_hold_done0", force_halt_done[0], 0);
            chk("t4_hold_hb0", dec_tlu_force_halt_bus[0], 1);
        end
        chk("t4_done1", force_halt_done[1], 1);
        lsu_bus_buffer_empty_any = 2'b11;
        found = 0;
        for (int i = 1; i <= 6 && !found; i++) begin
            tick();
            if (force_halt_done[0]) found = 1;
        end
        chk("t4_done0_seen", found, 1);
        dec_tlu_force_halt = 2'b00;
        tick();
        chk("t4_clr_hb", dec_tlu_force_halt_bus, 0);
        chk("t4_clr_done", force_halt_done, 0);

        // 5: one-cycle pulse while armed, dropped just as a bus edge arrives
        for (int i = 0; i < 8 && m_cnt != 2; i++) tick();
        dec_tlu_force_halt = 2'b01;
        tick();
        dec_tlu_force_halt = 2'b00;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_no_halt", dec_tlu_force_halt_bus, 0);
        end

        // 6: reset while halted with an update pending
        dec_tlu_force_halt = 2'b01;
        lsu_bus_buffer_empty_any = 2'b00;
        found = 0;
        for (int i = 1; i <= 8 && !found; i++) begin
            tick();
            if (dec_tlu_force_halt_bus[0]) found = 1;
        end
        chk("t6_halt_seen", found, 1);
        for (int i = 0; i < 8 && m_cnt == m_ratio; i++) tick();
        bus_ratio = 3'd6; ratio_update = 1'b1;
        tick();
        ratio_update = 1'b0;
        chk("t6_pend", ratio_pend, 1);
        chk("t6_hb", dec_tlu_force_halt_bus[0], 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("t6_async");
        model_reset();
        dec_tlu_force_halt = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_state("t6_held");
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("t6_first_pulse", lsu_bus_clk_en, (e == 4));
        end
        chk("t6_ratio_rst", ratio_q, RR);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eh2_lsu_busclk_ctl.md
Name: eh2_lsu_busclk_ctl

Overview:
Generates the LSU bus clock enable (lsu_bus_clk_en) for a programmable core-to-bus clock ratio. Also produces the bus-synchronized force-halt (dec_tlu_force_halt_bus) per thread. Sits directly upstream of the LSU clock-domain block, which consumes both outputs to gate lsu_busm_clk and the per-thread bus-buffer clocks.

Parameters:
NUM_THREADS, 1, number of hardware threads.
RATIO_W, 3, width of the ratio code; ratio code r means one bus cycle per r+1 core cycles.
RST_RATIO, 0, ratio code loaded at reset.

Ports:
clk  input  1  free-running core clock
rst  input  1  reset, asynchronous, active-high
bus_ratio  input  RATIO_W  requested ratio code
ratio_update  input  1  single-cycle request to adopt bus_ratio
dec_tlu_force_halt  input  NUM_THREADS  per-thread force-halt request, level
lsu_bus_buffer_empty_any  input  NUM_THREADS  per-thread bus buffer empty
lsu_bus_clk_en  output  1  bus clock enable, one-cycle pulse per bus cycle
lsu_bus_clk_en_q  output  1  lsu_bus_clk_en delayed one core cycle
dec_tlu_force_halt_bus  output  NUM_THREADS  force-halt aligned to bus-cycle boundaries
force_halt_done  output  NUM_THREADS  bus side is quiesced for this thread's halt
ratio_q  output  RATIO_W  ratio code currently in effect
ratio_pend  output  1  an update is waiting for a bus boundary

Behaviour:
- Reset values (async on rst=1):
  - cnt=0, ratio_q=RST_RATIO, ratio_pend=0.
  - lsu_bus_clk_en=0, lsu_bus_clk_en_q=0.
  - All thread FSMs are IDLE; all dec_tlu_force_halt_bus and force_halt_done outputs are 0.
- Divider (cnt is RATIO_W bits):
  - Every edge: if cnt==ratio_q, then cnt<=0 and lsu_bus_clk_en<=1. Otherwise cnt<=cnt+1 and lsu_bus_clk_en<=0.
  - lsu_bus_clk_en is registered. It is high exactly one cycle in every ratio_q+1 cycles.
  - The first pulse follows edge ratio_q+1 after reset release.
  - Ratio 0 gives lsu_bus_clk_en=1 every cycle from edge 1 onward.
- Boundary edge: the edge on which cnt==ratio_q.
- Ratio update:
  - When ratio_update=1 and the current edge is not a boundary edge: pend_ratio<=bus_ratio, ratio_pend<=1.
  - A second ratio_update while pending overwrites pend_ratio (last value wins).
  - On a boundary edge with ratio_pend=1: ratio_q<=pend_ratio, ratio_pend<=0.
  - If ratio_update=1 on the boundary edge itself: ratio_q<=bus_ratio directly (bypass), ratio_pend<=0. This takes priority over any older pending value.
  - cnt always restarts at 0 on a boundary edge, so the next pulse comes new_ratio+1 cycles later. No short or merged pulses are allowed.
- Force-halt FSM (per thread i; "bus edge" = edge on which lsu_bus_clk_en=1):
  - IDLE: dec_tlu_force_halt[i]=1 -> ARMED.
  - ARMED: dec_tlu_force_halt[i]=0 -> IDLE. Otherwise, on a bus edge -> HALT.
  - HALT: dec_tlu_force_halt_bus[i]=1. On a bus edge with lsu_bus_buffer_empty_any[i]=1 -> DONE. Deasserting the request while in HALT does not abort.
  - DONE: dec_tlu_force_halt_bus[i]=1 and force_halt_done[i]=1. dec_tlu_force_halt[i]=0 -> IDLE, with both outputs dropping on that edge.
  - Outputs are decoded from registered state; there is no combinational path from inputs.
- lsu_bus_clk_en_q: simple one-cycle delay of lsu_bus_clk_en.
- Reset mid-operation: all state returns to the reset values immediately. A pending ratio update is discarded.
- Threads are fully independent. Simultaneous halts on several threads all advance on the same bus edge.

Test Plan:
1. Reset release with RST_RATIO=3 -> lsu_bus_clk_en high after edges 4, 8, 12; lsu_bus_clk_en_q high after edges 5, 9, 13.
2. Ratio 3 running; ratio_update=1 with bus_ratio=1 at cnt=1 -> ratio_pend=1 for 2 cycles. The pulse at the edge where cnt is 3 is unchanged. Subsequent pulses come every 2 cycles, and ratio_q=1.
3. ratio_update on a boundary edge with bus_ratio=0, while ratio_pend holds 5 -> ratio_q=0 immediately, ratio_pend=0. lsu_bus_clk_en is high every following cycle.
4. Ratio 2; dec_tlu_force_halt[0]=1 at cnt=0 -> dec_tlu_force_halt_bus[0] rises after the next bus edge. With lsu_bus_buffer_empty_any[0]=0 it holds; when empty=1, force_halt_done[0] rises after the next bus edge. Dropping dec_tlu_force_halt clears both outputs one cycle later.
5. Force-halt pulsed for 1 cycle while ARMED, before any bus edge -> FSM returns to IDLE; dec_tlu_force_halt_bus never asserts.
6. Assert rst while in HALT with ratio_pend=1 -> all outputs return to 0 asynchronously; ratio_q=RST_RATIO; first pulse comes RST_RATIO+1 edges after release.
